// File: rtl/flit_injector.sv
// flit_injector: turns a payload stream into HEADER/BODY/TAIL flits for one NoC injection port.
// Optional: define INJ_PARITY_EN to build the flit_par_o parity output (tied low otherwise).
module flit_injector #(
    parameter int unsigned FLIT_W = 32,
    parameter logic [3:0]  SRC_ID = 4'd3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [3:0]        dest_i,
    input  logic [11:0]       pkt_len_i,
    input  logic [FLIT_W-1:0] pl_data_i,
    input  logic              pl_valid_i,
    output logic              pl_ready_o,
    input  logic              grant_i,
    input  logic              dn_full_i,
    output logic              req_o,
    output logic [2:0]        flit_type_o,
    output logic [11:0]       length_o,
    output logic [FLIT_W-1:0] flit_out_o,
    output logic              flit_valid_o,
    output logic              busy_o,
    output logic              err_o,
    output logic              flit_par_o
);

    localparam logic [2:0] TypeNone = 3'b000;
    localparam logic [2:0] TypeHead = 3'b001;
    localparam logic [2:0] TypeBody = 3'b010;
    localparam logic [2:0] TypeTail = 3'b100;

    typedef enum logic [4:0] {
        StIdle = 5'b00001,
        StReq  = 5'b00010,
        StHead = 5'b00100,
        StBody = 5'b01000,
        StTail = 5'b10000
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        dest_q, dest_d;
    logic [11:0]       len_q, len_d;
    logic [11:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              link_ok;
    logic              emit;
    logic [FLIT_W-1:0] header;

    assign link_ok = grant_i & ~dn_full_i;
    assign header  = {dest_q, SRC_ID, len_q, {(FLIT_W - 20){1'b0}}};

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        pl_ready_o   = 1'b0;
        flit_valid_o = 1'b0;
        flit_type_o  = TypeNone;
        flit_out_o   = '0;
        emit         = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_i) begin
                    if (pkt_len_i >= 12'd2) begin
                        dest_d  = dest_i;
                        len_d   = pkt_len_i;
                        state_d = StReq;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (grant_i) begin
                    state_d = StHead;
                end
            end
            StHead: begin
                if (link_ok) begin
                    flit_valid_o = 1'b1;
                    flit_type_o  = TypeHead;
                    flit_out_o   = header;
                    cnt_d        = 12'd1;
                    state_d      = (len_q == 12'd2) ? StTail : StBody;
                end
            end
            StBody: begin
                pl_ready_o = link_ok;
                emit       = link_ok & pl_valid_i;
                if (emit) begin
                    flit_valid_o = 1'b1;
                    flit_type_o  = TypeBody;
                    flit_out_o   = pl_data_i;
                    cnt_d        = cnt_q + 12'd1;
                    // Last body flit hands over to TAIL so the final word is typed correctly.
                    if (cnt_d == len_q - 12'd1) begin
                        state_d = StTail;
                    end
                end
            end
            StTail: begin
                pl_ready_o = link_ok;
                emit       = link_ok & pl_valid_i;
                if (emit) begin
                    flit_valid_o = 1'b1;
                    flit_type_o  = TypeTail;
                    flit_out_o   = pl_data_i;
                    cnt_d        = cnt_q + 12'd1;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            dest_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign req_o    = (state_q != StIdle);
    assign busy_o   = (state_q != StIdle);
    assign err_o    = err_q;
    assign length_o = len_q;

`ifdef INJ_PARITY_EN
    assign flit_par_o = flit_valid_o & (^{flit_out_o, flit_type_o});
`else
    assign flit_par_o = 1'b0;
`endif

    a_state_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot(state_q));
    a_valid_has_req : assert property (@(posedge clk_i) disable iff (!rst_ni) flit_valid_o |-> req_o);

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector: directed scenarios plus randomized traffic
// compared against a packet-level reference model.
module tb_flit_injector;

    localparam int unsigned FW  = 32;
    localparam logic [3:0]  SRC = 4'd3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [3:0]    dest     = '0;
    logic [11:0]   pkt_len  = '0;
    logic [FW-1:0] pl_data  = '0;
    logic          pl_valid = 1'b0;
    logic          grant    = 1'b0;
    logic          dn_full  = 1'b0;
    logic          pl_ready, req, flit_valid, busy, err, flit_par;
    logic [2:0]    flit_type;
    logic [11:0]   length;
    logic [FW-1:0] flit_out;

    int n_checks = 0;
    int n_pass   = 0;

    flit_injector #(.FLIT_W(FW), .SRC_ID(SRC)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .dest_i      (dest),
        .pkt_len_i   (pkt_len),
        .pl_data_i   (pl_data),
        .pl_valid_i  (pl_valid),
        .pl_ready_o  (pl_ready),
        .grant_i     (grant),
        .dn_full_i   (dn_full),
        .req_o       (req),
        .flit_type_o (flit_type),
        .length_o    (length),
        .flit_out_o  (flit_out),
        .flit_valid_o(flit_valid),
        .busy_o      (busy),
        .err_o       (err),
        .flit_par_o  (flit_par)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = waiting for grant, 2 = sending m_sent of m_len flits.
    int            m_phase, m_sent;
    logic [3:0]    m_dest;
    logic [11:0]   m_len;
    logic          m_err;
    logic          e_valid, e_plr, e_par;
    logic [2:0]    e_type;
    logic [FW-1:0] e_data;

    function automatic logic [FW-1:0] hdr_word(input logic [3:0] d, input logic [11:0] l);
        logic [FW-1:0] h;
        h = '0;
        h[FW-1 -: 4]  = d;
        h[FW-5 -: 4]  = SRC;
        h[FW-9 -: 12] = l;
        return h;
    endfunction

    always_comb begin
        e_valid = 1'b0;
        e_plr   = 1'b0;
        e_type  = 3'b000;
        e_data  = '0;
        if (m_phase == 2) begin
            if (m_sent == 0) begin
                e_valid = grant && !dn_full;
                if (e_valid) begin
                    e_type = 3'b001;
                    e_data = hdr_word(m_dest, m_len);
                end
            end else begin
                e_plr   = grant && !dn_full;
                e_valid = e_plr && pl_valid;
                if (e_valid) begin
                    e_type = (m_sent == int'(m_len) - 1) ? 3'b100 : 3'b010;
                    e_data = pl_data;
                end
            end
        end
`ifdef INJ_PARITY_EN
        e_par = e_valid && (($countones({e_data, e_type}) % 2) == 1);
`else
        e_par = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_sent  <= 0;
            m_dest  <= '0;
            m_len   <= '0;
            m_err   <= 1'b0;
        end else begin
            m_err <= (m_phase == 0) && start && (pkt_len < 12'd2);
            if (m_phase == 0 && start && pkt_len >= 12'd2) begin
                m_phase <= 1;
                m_dest  <= dest;
                m_len   <= pkt_len;
            end else if (m_phase == 1 && grant) begin
                m_phase <= 2;
                m_sent  <= 0;
            end else if (m_phase == 2 && e_valid) begin
                m_sent <= m_sent + 1;
                if (m_sent + 1 == int'(m_len)) m_phase <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; pkt_len = 12'd4; dest = 4'd9;
        grant = 1'b1; pl_valid = 1'b1; pl_data = $urandom;
        @(negedge clk);
        n_checks++;
        if ({req, busy, flit_valid, pl_ready, err, flit_par} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {req, busy, flit_valid, pl_ready, err, flit_par});
        else n_pass++;
        n_checks++;
        if ({flit_type, length, flit_out} !== '0)
            $display("FAIL reset_data: got type=%b len=%0d data=%h want all zero", flit_type, length, flit_out);
        else n_pass++;
        tick();
        rst_n = 1'b1; grant = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req !== 1'b0) $display("FAIL release_idle: got req=%b want 0", req); else n_pass++;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req !== 1'b1 || busy !== 1'b1 || length !== 12'd4)
            $display("FAIL first_start: got req=%b busy=%b len=%0d want 1 1 4", req, busy, length);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (req !== 1'b0 || length !== 12'd0)
            $display("FAIL reset_abort: got req=%b len=%0d want 0 0", req, length);
        else n_pass++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [2:0] want[4];
        logic       want_par;
        want = '{3'b001, 3'b010, 3'b010, 3'b100};
        grant = 1'b1; dn_full = 1'b0; pl_valid = 1'b1;
        dest = 4'd2; pkt_len = 12'd4; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req !== 1'b1 || flit_valid !== 1'b0)
            $display("FAIL basic_req: got req=%b valid=%b want 1 0", req, flit_valid);
        else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            pl_data = $urandom;
            @(negedge clk);
            n_checks++;
            if (flit_valid !== 1'b1 || flit_type !== want[i])
                $display("FAIL basic_type%0d: got valid=%b type=%b want 1 %b", i, flit_valid, flit_type, want[i]);
            else n_pass++;
            n_checks++;
            if (flit_out !== ((i == 0) ? 32'h2300_4000 : pl_data))
                $display("FAIL basic_data%0d: got %h want %h", i, flit_out, (i == 0) ? 32'h2300_4000 : pl_data);
            else n_pass++;
            n_checks++;
            if (length !== 12'd4) $display("FAIL basic_len%0d: got %0d want 4", i, length); else n_pass++;
            if (i == 0) begin
`ifdef INJ_PARITY_EN
                want_par = 1'b1;
`else
                want_par = 1'b0;
`endif
                n_checks++;
                if (flit_par !== want_par) $display("FAIL basic_par: got %b want %b", flit_par, want_par);
                else n_pass++;
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (req !== 1'b0 || busy !== 1'b0 || flit_valid !== 1'b0)
            $display("FAIL basic_done: got req=%b busy=%b valid=%b want 0 0 0", req, busy, flit_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_short();
        dest = 4'd5; pkt_len = 12'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (flit_valid !== 1'b1 || flit_type !== 3'b001)
            $display("FAIL short_head: got valid=%b type=%b want 1 001", flit_valid, flit_type);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (flit_valid !== 1'b1 || flit_type !== 3'b100)
            $display("FAIL short_tail: got valid=%b type=%b want 1 100", flit_valid, flit_type);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (req !== 1'b0) $display("FAIL short_done: got req=%b want 0", req); else n_pass++;
        pkt_len = 12'd1; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || req !== 1'b0)
            $display("FAIL len1_err: got err=%b req=%b want 1 0", err, req);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || req !== 1'b0)
            $display("FAIL len1_after: got err=%b req=%b want 0 0", err, req);
        else n_pass++;
        tick();
    endtask

    task automatic test_grant_gap();
        int         got;
        logic [2:0] last;
        got = 0; last = 3'b000;
        dest = 4'd11; pkt_len = 12'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            pl_data = $urandom;
            @(negedge clk);
            if (flit_valid === 1'b1) got++;
            tick();
        end
        n_checks++;
        if (got != 2) $display("FAIL gap_pre: got %0d flits want 2", got); else n_pass++;
        grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (flit_valid !== 1'b0 || pl_ready !== 1'b0 || req !== 1'b1)
                $display("FAIL gap_stall%0d: got valid=%b ready=%b req=%b want 0 0 1", i, flit_valid, pl_ready, req);
            else n_pass++;
            tick();
        end
        grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pl_data = $urandom;
            @(negedge clk);
            if (flit_valid === 1'b1) begin
                got++;
                last = flit_type;
            end
            tick();
        end
        n_checks++;
        if (got != 5 || last !== 3'b100)
            $display("FAIL gap_total: got %0d flits last=%b want 5 100", got, last);
        else n_pass++;
    endtask

    task automatic test_dn_full();
        int got;
        got = 0;
        dest = 4'd6; pkt_len = 12'd3; start = 1'b1;
        tick();
        start = 1'b0; dn_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (flit_valid !== 1'b0 || pl_ready !== 1'b0)
                $display("FAIL full_stall%0d: got valid=%b ready=%b want 0 0", i, flit_valid, pl_ready);
            else n_pass++;
        end
        tick();
        dn_full = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flit_valid !== 1'b1 || flit_type !== 3'b001 || flit_out !== hdr_word(4'd6, 12'd3))
            $display("FAIL full_head: got valid=%b type=%b data=%h want 1 001 %h",
                     flit_valid, flit_type, flit_out, hdr_word(4'd6, 12'd3));
        else n_pass++;
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (flit_valid === 1'b1) got++;
            tick();
        end
        n_checks++;
        if (got != 2) $display("FAIL full_rest: got %0d flits want 2", got); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int         got;
        logic [2:0] first, last;
        got = 0; first = 3'b000; last = 3'b000;
        dest = 4'd1; pkt_len = 12'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (flit_valid === 1'b1) got++;
            tick();
        end
        n_checks++;
        if (got != 2) $display("FAIL mid_pre: got %0d flits want 2", got); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req, busy, flit_valid, pl_ready, err, flit_par, flit_type, length, flit_out} !== '0)
            $display("FAIL mid_reset: got req=%b busy=%b valid=%b ready=%b type=%b len=%0d data=%h want all zero",
                     req, busy, flit_valid, pl_ready, flit_type, length, flit_out);
        else n_pass++;
        tick();
        rst_n = 1'b1; dest = 4'd7; pkt_len = 12'd3; start = 1'b1;
        got = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (flit_valid === 1'b1) begin
                if (got == 0) first = flit_type;
                last = flit_type;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got != 3 || first !== 3'b001 || last !== 3'b100)
            $display("FAIL mid_restart: got %0d flits first=%b last=%b want 3 001 100", got, first, last);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            grant    = ($urandom_range(0, 3) != 0);
            dn_full  = ($urandom_range(0, 4) == 0);
            pl_valid = ($urandom_range(0, 3) != 0);
            pl_data  = $urandom;
            start    = ($urandom_range(0, 5) == 0);
            pkt_len  = 12'($urandom_range(0, 9));
            dest     = 4'($urandom_range(0, 15));
            rst_n    = ($urandom_range(0, 299) != 0);
            @(negedge clk);
            n_checks++;
            if (flit_valid !== e_valid) $display("FAIL rnd_valid c%0d: got %b want %b", c, flit_valid, e_valid);
            else n_pass++;
            n_checks++;
            if (flit_type !== e_type) $display("FAIL rnd_type c%0d: got %b want %b", c, flit_type, e_type);
            else n_pass++;
            n_checks++;
            if (flit_out !== e_data) $display("FAIL rnd_data c%0d: got %h want %h", c, flit_out, e_data);
            else n_pass++;
            n_checks++;
            if (pl_ready !== e_plr) $display("FAIL rnd_ready c%0d: got %b want %b", c, pl_ready, e_plr);
            else n_pass++;
            n_checks++;
            if (req !== (m_phase != 0) || busy !== (m_phase != 0))
                $display("FAIL rnd_req c%0d: got req=%b busy=%b want %b", c, req, busy, m_phase != 0);
            else n_pass++;
            n_checks++;
            if (err !== m_err) $display("FAIL rnd_err c%0d: got %b want %b", c, err, m_err);
            else n_pass++;
            n_checks++;
            if (length !== m_len) $display("FAIL rnd_len c%0d: got %0d want %0d", c, length, m_len);
            else n_pass++;
            n_checks++;
            if (flit_par !== e_par) $display("FAIL rnd_par c%0d: got %b want %b", c, flit_par, e_par);
            else n_pass++;
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_grant_gap();
        test_dn_full();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
